// File: rtl/instr_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words, writes them
// sequentially into instruction memory and holds the CPU in reset until the image is complete.
module instr_loader #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic               im_we_o,
  output logic [31:0]        im_addr_o,
  output logic [31:0]        im_data_o,
  output logic               cpu_rst_n_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               full_o,
  output logic [DEPTH_W:0]   word_cnt_o
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

  localparam logic [DEPTH_W-1:0] TOP_IDX = '1;

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [DEPTH_W-1:0] word_idx_q, word_idx_d;
  logic [23:0]        shift_q, shift_d;
  logic [31:0]        data_q, data_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic [DEPTH_W:0]   cnt_q, cnt_d;
  logic               full_q, full_d;

  // Handshake: a byte transfers on a rising edge where byte_valid_i and byte_ready_o are both high.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = RECV;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          cnt_d      = '0;
          full_d     = 1'b0;
        end
      end
      RECV: begin
        if (byte_valid_i) begin
          shift_d    = {shift_q[15:0], byte_i};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Latch the word and its address so they stay stable through WRITE and after.
            data_d  = {shift_q, byte_i};
            addr_d  = word_idx_q;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (data_q == 32'd0) begin
          state_d = DONE;
        end else if (word_idx_q == TOP_IDX) begin
          state_d = DONE;
          full_d  = 1'b1;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      word_idx_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
    end
  end

  assign byte_ready_o = (state_q == RECV);
  assign im_we_o      = (state_q == WRITE);
  assign im_addr_o    = {{(30 - DEPTH_W){1'b0}}, addr_q, 2'b00};
  assign im_data_o    = data_q;
  assign cpu_rst_n_o  = (state_q == DONE);
  assign busy_o       = (state_q == RECV) || (state_q == WRITE);
  assign done_o       = (state_q == DONE);
  assign full_o       = full_q;
  assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: stimulus pushes expected memory writes into a queue,
// a negedge monitor pops and compares each write the loader issues.
module tb_instr_loader;
  localparam int DW = 2;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [7:0]    byte_i;
  logic          byte_valid_i;
  logic          byte_ready_o;
  logic          im_we_o;
  logic [31:0]   im_addr_o;
  logic [31:0]   im_data_o;
  logic          cpu_rst_n_o;
  logic          busy_o;
  logic          done_o;
  logic          full_o;
  logic [DW:0]   word_cnt_o;

  instr_loader #(.DEPTH_W(DW)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .im_we_o(im_we_o),
    .im_addr_o(im_addr_o), .im_data_o(im_data_o), .cpu_rst_n_o(cpu_rst_n_o),
    .busy_o(busy_o), .done_o(done_o), .full_o(full_o), .word_cnt_o(word_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int          wr_cyc_q[$];
  int          tests = 0;
  int          fails = 0;

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk_i) begin
    if (im_we_o === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", im_addr_o, im_data_o);
      end else begin
        check("write", {32'd0, im_addr_o, im_data_o}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(output int c);
    start_i = 1'b1;
    tick();
    c = cyc;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit with_start);
    int n;
    bit acc;
    if (gap) begin
      byte_valid_i = 1'b0;
      tick();
    end
    byte_valid_i = 1'b1;
    byte_i = b;
    start_i = with_start;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk_i);
      acc = byte_ready_o;
      tick();
      start_i = 1'b0;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout: got ready=0 for 50 cycles, required acceptance of 0x%0h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap, 1'b0);
  endtask

  // Returns at the negedge where done_o is first seen (or after the budget).
  task automatic wait_done;
    int n;
    byte_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (done_o !== 1'b1 && n < 200);
    check("done_reached", done_o, 1);
  endtask

  task automatic check_latency(input string name, input int c, input int exp_delta);
    if (wr_cyc_q.size() == 0) check(name, 96'hffff, exp_delta);
    else check(name, wr_cyc_q[0] - c, exp_delta);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;

    // Reset then idle
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("idle_outputs", {byte_ready_o, im_we_o, im_addr_o, im_data_o, cpu_rst_n_o,
                             busy_o, done_o, full_o, word_cnt_o}, 0);
    end
    tick();

    // Single word plus terminator, continuous valid
    wr_cyc_q.delete();
    exp_q.push_back({32'h0, 32'h20010005});
    exp_q.push_back({32'h4, 32'h00000000});
    pulse_start(c);
    send_word(32'h20010005, 1'b0);
    send_word(32'h00000000, 1'b0);
    wait_done();
    check("single_cpu_rst_n", cpu_rst_n_o, 1);
    check("single_word_cnt", word_cnt_o, 2);
    check("single_full", full_o, 0);
    check("single_busy", busy_o, 0);
    check_latency("single_first_write_cycle", c, 4);
    tick();

    // Same stream with valid low on alternate cycles
    wr_cyc_q.delete();
    exp_q.push_back({32'h0, 32'h20010005});
    exp_q.push_back({32'h4, 32'h00000000});
    pulse_start(c);
    send_word(32'h20010005, 1'b1);
    send_word(32'h00000000, 1'b1);
    wait_done();
    check("gap_word_cnt", word_cnt_o, 2);
    check_latency("gap_first_write_cycle", c, 8);
    check("gap_write_count", wr_cyc_q.size(), 2);
    tick();

    // Full memory: four non-zero words, no terminator
    for (int i = 0; i < 4; i++) exp_q.push_back({32'(4 * i), 32'(i + 1)});
    pulse_start(c);
    for (int i = 0; i < 4; i++) send_word(32'(i + 1), 1'b0);
    wait_done();
    check("full_flag", full_o, 1);
    check("full_word_cnt", word_cnt_o, 4);
    check("full_cpu_rst_n", cpu_rst_n_o, 1);
    byte_valid_i = 1'b1;
    byte_i = 8'h05;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("full_no_ready", byte_ready_o, 0);
    end
    check("full_word_cnt_hold", word_cnt_o, 4);
    byte_valid_i = 1'b0;
    tick();

    // Reset in mid-word discards the partial word
    pulse_start(c);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    byte_valid_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk_i);
    check("midreset_outputs", {byte_ready_o, im_we_o, im_addr_o, im_data_o, cpu_rst_n_o,
                               busy_o, done_o, full_o, word_cnt_o}, 0);
    tick();
    exp_q.push_back({32'h0, 32'h00000000});
    pulse_start(c);
    send_word(32'h00000000, 1'b0);
    wait_done();
    check("midreset_word_cnt", word_cnt_o, 1);
    check("midreset_full", full_o, 0);
    tick();

    // Reload from DONE, with start pulses during RECV
    exp_q.push_back({32'h0, 32'h8C010004});
    exp_q.push_back({32'h4, 32'h00000000});
    pulse_start(c);
    @(negedge clk_i);
    check("reload_cpu_rst_low", cpu_rst_n_o, 0);
    check("reload_busy", busy_o, 1);
    check("reload_cnt_cleared", word_cnt_o, 0);
    tick();
    send_byte(8'h8C, 1'b0, 1'b1);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    send_byte(8'h04, 1'b0, 1'b0);
    send_word(32'h00000000, 1'b0);
    wait_done();
    check("reload_cpu_rst_high", cpu_rst_n_o, 1);
    check("reload_word_cnt", word_cnt_o, 2);
    tick();

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Hardware program loader for the single-cycle MIPS CPU. It accepts a byte stream over a valid/ready handshake and packs the bytes into 32-bit instruction words. It writes those words sequentially into the CPU instruction memory and holds the CPU in reset until a zero terminator word has been written. It is the write side of the instruction-memory image that the CPU fetches from and that the bench scans until it hits the first zero word.

## Interface
Parameters:
- DEPTH_W, 8: word-address width; instruction memory holds 2^DEPTH_W words.

Ports:
- clk_i, input, 1: system clock; all state changes on rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- start_i, input, 1: one-cycle request to begin a load; honoured in IDLE and DONE only.
- byte_i, input, 8: stream byte; first byte of each word = instruction bits [31:24] (big-endian).
- byte_valid_i, input, 1: byte_i valid.
- byte_ready_o, output, 1: loader accepts a byte this cycle.
- im_we_o, output, 1: instruction-memory write strobe.
- im_addr_o, output, 32: byte address of the write, = word_idx<<2, bits [1:0] = 0.
- im_data_o, output, 32: packed instruction word.
- cpu_rst_n_o, output, 1: active-low reset to the CPU; 0 while not DONE.
- busy_o, output, 1: state is RECV or WRITE.
- done_o, output, 1: state is DONE.
- full_o, output, 1: load ended by filling memory without a terminator.
- word_cnt_o, output, DEPTH_W+1: words written in the current load, including the terminator.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- Reset (rst_n=0 at an edge) from any state:
  - state=IDLE; byte_ready_o=0, im_we_o=0, im_addr_o=0, im_data_o=0, cpu_rst_n_o=0, busy_o=0, done_o=0, full_o=0, word_cnt_o=0.
  - Internal byte index=0, word_idx=0, shift register=0.
  - A reset in mid-load discards the partial word. Memory already written is not cleared.
- IDLE: start_i=1 → RECV. Byte index, word_idx, word_cnt_o and full_o are cleared.
- RECV:
  - byte_ready_o=1.
  - On byte_valid_i & byte_ready_o: shift register = {shift[23:0], byte_i}; byte index increments.
  - On acceptance of the 4th byte (index 3): byte index returns to 0 and the state goes to WRITE.
  - A byte_valid_i gap has no effect. start_i is ignored.
- WRITE (exactly one cycle):
  - im_we_o=1; im_addr_o = {word_idx, 2'b00} zero-extended to 32 bits; im_data_o = assembled word; byte_ready_o=0.
  - word_cnt_o increments at the end of this cycle.
  - If the word = 0 → DONE.
  - Else if word_idx = 2^DEPTH_W−1 → DONE with full_o=1.
  - Else word_idx+1 → RECV.
- DONE:
  - cpu_rst_n_o=1, done_o=1, byte_ready_o=0.
  - start_i=1 → RECV. word_idx, word_cnt_o and full_o are cleared, and cpu_rst_n_o drops to 0 in the following cycle.
- im_addr_o and im_data_o hold their last values when im_we_o=0. They are don't-care to the memory.
- word_idx never wraps. Reaching the top address always terminates the load.

## Timing
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs.
- Minimum rate is 5 cycles per word: 4 byte-accept cycles followed by 1 WRITE cycle. byte_ready_o is low during WRITE.
- im_we_o is high during the cycle after the edge that accepted the 4th byte.
- cpu_rst_n_o and done_o rise in the cycle after the WRITE cycle of the terminator (or of the top-address word). The CPU therefore leaves reset with the complete image in memory, and its first fetch is from address 0.
- start_i and byte_valid_i arriving in the same cycle in IDLE: only start is taken. The byte is not accepted because byte_ready_o=0.
- rst_n=0 has priority over every other input.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, release. All outputs are 0, and cpu_rst_n_o=0 for 10 idle cycles.
- Single word plus terminator:
  - Stimulus: start_i, then bytes 20 01 00 05 00 00 00 00 with valid held high.
  - First write: im_we_o at cycle 5 after RECV entry, addr 0x0, data 0x20010005.
  - Second write: addr 0x4, data 0x00000000.
  - Then done_o=1, cpu_rst_n_o=1, word_cnt_o=2, full_o=0.
- Valid gaps:
  - Stimulus: same stream with byte_valid_i low on alternate cycles.
  - Same writes and data. The first write comes 4 cycles later than with continuous valid.
  - No byte is duplicated or dropped.
- Full memory (DEPTH_W=2):
  - Stimulus: 4 non-zero words 0x00000001..0x00000004.
  - Writes go to addresses 0x0, 0x4, 0x8, 0xC; then done_o=1, full_o=1, word_cnt_o=4.
  - A 5th word offered afterwards is not accepted (byte_ready_o=0).
- Reset mid-word:
  - Stimulus: 2 bytes accepted, then rst_n=0 for 1 cycle, then start_i, then 00 00 00 00.
  - Exactly one write: addr 0x0, data 0x00000000. The earlier bytes leave no trace.
- Reload from DONE:
  - Stimulus: after a completed load, assert start_i and send 8C 01 00 04 00 00 00 00.
  - cpu_rst_n_o=0 in the next cycle.
  - Writes: addr 0x0 data 0x8C010004, then addr 0x4 data 0x00000000.
  - cpu_rst_n_o returns to 1 afterwards. start_i pulses during RECV are ignored.
